// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 control unit.
//   - opcode constants (IR[15:12])
//   - ALU function codes driven on M
//   - control-unit state enum
//   - execute-phase control bundle produced by mu0_decode
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_Y   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // acc_en here means "load the accumulator once memory is ready";
  // the caller qualifies it with Mem_Ready.
  typedef struct packed {
    logic       addr_sel;
    logic       x_sel;
    logic       y_sel;
    logic [1:0] m;
    logic       pc_en;
    logic       acc_en;
    logic       rd;
    logic       wr;
    logic       mem_op;
    logic       stop;
  } exec_ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// mu0_decode: combinational map from opcode and accumulator flags to the
// execute-phase controls. Also usable stand-alone by trace/disassembly logic.
// Ports:
//   F    in  [3:0] opcode
//   N    in        accumulator negative flag
//   Z    in        accumulator zero flag
//   ctrl out       execute-phase control bundle (exec_ctrl_t)
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output exec_ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (F)
      OP_LDA: begin
        ctrl.addr_sel = 1'b1;
        ctrl.rd       = 1'b1;
        ctrl.m        = ALU_Y;
        ctrl.acc_en   = 1'b1;
        ctrl.mem_op   = 1'b1;
      end
      OP_STA: begin
        ctrl.addr_sel = 1'b1;
        ctrl.wr       = 1'b1;
        ctrl.mem_op   = 1'b1;
      end
      OP_ADD: begin
        ctrl.addr_sel = 1'b1;
        ctrl.rd       = 1'b1;
        ctrl.m        = ALU_ADD;
        ctrl.acc_en   = 1'b1;
        ctrl.mem_op   = 1'b1;
      end
      OP_SUB: begin
        ctrl.addr_sel = 1'b1;
        ctrl.rd       = 1'b1;
        ctrl.m        = ALU_SUB;
        ctrl.acc_en   = 1'b1;
        ctrl.mem_op   = 1'b1;
      end
      OP_JMP: begin
        ctrl.y_sel = 1'b1;
        ctrl.m     = ALU_Y;
        ctrl.pc_en = 1'b1;
      end
      OP_JGE: begin
        ctrl.y_sel = 1'b1;
        ctrl.m     = ALU_Y;
        ctrl.pc_en = ~N;
      end
      OP_JNE: begin
        ctrl.y_sel = 1'b1;
        ctrl.m     = ALU_Y;
        ctrl.pc_en = ~Z;
      end
      OP_STP: begin
        ctrl.stop = 1'b1;
      end
      default: begin
        // 8..F: no-op, everything stays at its default of zero
      end
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// mu0_control: MU0 control unit. Sequences fetch/execute, stretches memory
// cycles while Mem_Ready is low and parks in HALT after STP.
// Ports:
//   Clk, Reset            clock; async active-high reset to FETCH
//   F[3:0], N, Z          opcode and accumulator flags from the datapath
//   Mem_Ready             memory completes the current access this cycle
//   Addr_sel, X_sel, Y_sel, M[1:0]   datapath mux selects / ALU function
//   PC_En, IR_En, Acc_En  register load enables
//   Rd, Wr                memory strobes
//   Fetch, Halted         state indicators
//
// state   | meaning
// S_FETCH | read instruction at PC, PC <= PC+1 and IR load when memory ready
// S_EXEC  | carry out the opcode in IR; memory opcodes wait for Mem_Ready
// S_HALT  | stopped after STP; only Reset leaves
module mu0_control
  import mu0_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Mem_Ready,
  output logic       Addr_sel,
  output logic       X_sel,
  output logic       Y_sel,
  output logic [1:0] M,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       Rd,
  output logic       Wr,
  output logic       Fetch,
  output logic       Halted
);

  state_t     state_q;
  state_t     state_d;
  exec_ctrl_t ex;

  mu0_decode u_decode (
    .F    (F),
    .N    (N),
    .Z    (Z),
    .ctrl (ex)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    Addr_sel = 1'b0;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    M        = ALU_Y;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Fetch    = 1'b0;
    Halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        Fetch = 1'b1;
        Rd    = 1'b1;
        X_sel = 1'b1;
        M     = ALU_INC;
        IR_En = Mem_Ready;
        PC_En = Mem_Ready;
        if (Mem_Ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        Addr_sel = ex.addr_sel;
        X_sel    = ex.x_sel;
        Y_sel    = ex.y_sel;
        M        = ex.m;
        PC_En    = ex.pc_en;
        Acc_En   = ex.acc_en & Mem_Ready;
        Rd       = ex.rd;
        Wr       = ex.wr;
        if (ex.stop)                     state_d = S_HALT;
        else if (!ex.mem_op || Mem_Ready) state_d = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Strobes and enables drop the moment Reset rises, not at the next edge.
    if (Reset) begin
      PC_En  = 1'b0;
      IR_En  = 1'b0;
      Acc_En = 1'b0;
      Rd     = 1'b0;
      Wr     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
module tb_mu0_control;

  logic       Clk;
  logic       Reset;
  logic [3:0] F;
  logic       N;
  logic       Z;
  logic       Mem_Ready;
  logic       Addr_sel, X_sel, Y_sel;
  logic [1:0] M;
  logic       PC_En, IR_En, Acc_En, Rd, Wr, Fetch, Halted;

  int compared   = 0;
  int mismatched = 0;

  // expected output vectors, pushed when a step is driven, popped when sampled
  logic [12:0] sb[$];

  typedef struct {
    logic        rst;
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic        mr;
    logic [12:0] exp;
  } step_t;

  mu0_control dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .F         (F),
    .N         (N),
    .Z         (Z),
    .Mem_Ready (Mem_Ready),
    .Addr_sel  (Addr_sel),
    .X_sel     (X_sel),
    .Y_sel     (Y_sel),
    .M         (M),
    .PC_En     (PC_En),
    .IR_En     (IR_En),
    .Acc_En    (Acc_En),
    .Rd        (Rd),
    .Wr        (Wr),
    .Fetch     (Fetch),
    .Halted    (Halted)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // {Addr_sel, X_sel, Y_sel, M, PC_En, IR_En, Acc_En, Rd, Wr, Fetch, Halted}
  function automatic logic [12:0] ev(logic a, logic x, logic y, logic [1:0] m,
                                     logic pc, logic ir, logic acc, logic rd,
                                     logic wr, logic f, logic h);
    return {a, x, y, m, pc, ir, acc, rd, wr, f, h};
  endfunction

  function automatic logic [12:0] obs();
    return {Addr_sel, X_sel, Y_sel, M, PC_En, IR_En, Acc_En, Rd, Wr, Fetch, Halted};
  endfunction

  function automatic step_t stp(logic rst, logic [3:0] f, logic n, logic z,
                                logic mr, logic [12:0] exp);
    step_t s;
    s.rst = rst; s.f = f; s.n = n; s.z = z; s.mr = mr; s.exp = exp;
    return s;
  endfunction

  // frequently used expectations
  logic [12:0] FETCH_RDY, FETCH_WAIT, FETCH_RST, EX_IDLE, HALT_V;
  initial begin
    FETCH_RDY  = ev(0,1,0,2'b10,1,1,0,1,0,1,0);
    FETCH_WAIT = ev(0,1,0,2'b10,0,0,0,1,0,1,0);
    FETCH_RST  = ev(0,1,0,2'b10,0,0,0,0,0,1,0);
    EX_IDLE    = ev(0,0,0,2'b00,0,0,0,0,0,0,0);
    HALT_V     = ev(0,0,0,2'b00,0,0,0,0,0,0,1);
  end

  task automatic test_reset();
    step_t st[$];
    logic [12:0] want, got;
    st.push_back(stp(1, 4'h2, 0, 0, 1, FETCH_RST));
    st.push_back(stp(0, 4'h2, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h2, 0, 0, 1, ev(1,0,0,2'b01,0,0,1,1,0,0,0)));
    for (int i = 0; i < st.size(); i++) begin
      Reset = st[i].rst; F = st[i].f; N = st[i].n; Z = st[i].z; Mem_Ready = st[i].mr;
      sb.push_back(st[i].exp);
      #3;
      want = sb.pop_front(); got = obs(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL reset step %0d: got %b want %b", i, got, want);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_add_wait();
    step_t st[$];
    logic [12:0] want, got;
    st.push_back(stp(0, 4'h2, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h2, 0, 0, 0, ev(1,0,0,2'b01,0,0,0,1,0,0,0)));
    st.push_back(stp(0, 4'h2, 0, 0, 0, ev(1,0,0,2'b01,0,0,0,1,0,0,0)));
    st.push_back(stp(0, 4'h2, 0, 0, 1, ev(1,0,0,2'b01,0,0,1,1,0,0,0)));
    st.push_back(stp(0, 4'h2, 0, 0, 0, FETCH_WAIT));
    st.push_back(stp(0, 4'h2, 0, 0, 0, FETCH_WAIT));
    for (int i = 0; i < st.size(); i++) begin
      Reset = st[i].rst; F = st[i].f; N = st[i].n; Z = st[i].z; Mem_Ready = st[i].mr;
      sb.push_back(st[i].exp);
      #3;
      want = sb.pop_front(); got = obs(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL add_wait step %0d: got %b want %b", i, got, want);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_jumps();
    step_t st[$];
    logic [12:0] want, got;
    st.push_back(stp(0, 4'h5, 1, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h5, 1, 0, 0, ev(0,0,1,2'b00,0,0,0,0,0,0,0)));
    st.push_back(stp(0, 4'h5, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h5, 0, 0, 0, ev(0,0,1,2'b00,1,0,0,0,0,0,0)));
    st.push_back(stp(0, 4'h6, 0, 1, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h6, 0, 1, 0, ev(0,0,1,2'b00,0,0,0,0,0,0,0)));
    st.push_back(stp(0, 4'h6, 1, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h6, 1, 0, 0, ev(0,0,1,2'b00,1,0,0,0,0,0,0)));
    st.push_back(stp(0, 4'h4, 1, 1, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h4, 1, 1, 0, ev(0,0,1,2'b00,1,0,0,0,0,0,0)));
    st.push_back(stp(0, 4'h4, 1, 1, 0, FETCH_WAIT));
    for (int i = 0; i < st.size(); i++) begin
      Reset = st[i].rst; F = st[i].f; N = st[i].n; Z = st[i].z; Mem_Ready = st[i].mr;
      sb.push_back(st[i].exp);
      #3;
      want = sb.pop_front(); got = obs(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL jumps step %0d: got %b want %b", i, got, want);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_sta();
    step_t st[$];
    logic [12:0] want, got;
    st.push_back(stp(0, 4'h1, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h1, 0, 0, 0, ev(1,0,0,2'b00,0,0,0,0,1,0,0)));
    st.push_back(stp(0, 4'h1, 0, 0, 1, ev(1,0,0,2'b00,0,0,0,0,1,0,0)));
    st.push_back(stp(0, 4'h1, 0, 0, 0, FETCH_WAIT));
    for (int i = 0; i < st.size(); i++) begin
      Reset = st[i].rst; F = st[i].f; N = st[i].n; Z = st[i].z; Mem_Ready = st[i].mr;
      sb.push_back(st[i].exp);
      #3;
      want = sb.pop_front(); got = obs(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL sta step %0d: got %b want %b", i, got, want);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    logic [12:0] want, got;
    st.push_back(stp(0, 4'h0, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h0, 0, 0, 1, ev(1,0,0,2'b00,0,0,1,1,0,0,0)));
    st.push_back(stp(0, 4'h3, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h3, 0, 0, 1, ev(1,0,0,2'b11,0,0,1,1,0,0,0)));
    st.push_back(stp(0, 4'h2, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h2, 0, 0, 1, ev(1,0,0,2'b01,0,0,1,1,0,0,0)));
    st.push_back(stp(0, 4'h2, 0, 0, 0, FETCH_WAIT));
    for (int i = 0; i < st.size(); i++) begin
      Reset = st[i].rst; F = st[i].f; N = st[i].n; Z = st[i].z; Mem_Ready = st[i].mr;
      sb.push_back(st[i].exp);
      #3;
      want = sb.pop_front(); got = obs(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL back_to_back step %0d: got %b want %b", i, got, want);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_nop_and_reset_wait();
    step_t st[$];
    logic [12:0] want, got;
    st.push_back(stp(0, 4'h9, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h9, 0, 0, 0, EX_IDLE));
    st.push_back(stp(0, 4'h9, 0, 0, 0, FETCH_WAIT));
    st.push_back(stp(1, 4'h9, 0, 0, 0, FETCH_RST));
    st.push_back(stp(0, 4'h9, 0, 0, 0, FETCH_WAIT));
    st.push_back(stp(0, 4'hF, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'hF, 0, 0, 1, EX_IDLE));
    st.push_back(stp(0, 4'hF, 0, 0, 0, FETCH_WAIT));
    for (int i = 0; i < st.size(); i++) begin
      Reset = st[i].rst; F = st[i].f; N = st[i].n; Z = st[i].z; Mem_Ready = st[i].mr;
      sb.push_back(st[i].exp);
      #3;
      want = sb.pop_front(); got = obs(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL nop_reset step %0d: got %b want %b", i, got, want);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_halt();
    step_t st[$];
    logic [12:0] want, got;
    st.push_back(stp(0, 4'h7, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h7, 0, 0, 0, EX_IDLE));
    st.push_back(stp(0, 4'h2, 0, 0, 1, HALT_V));
    st.push_back(stp(0, 4'h0, 1, 1, 1, HALT_V));
    st.push_back(stp(0, 4'h4, 0, 0, 0, HALT_V));
    st.push_back(stp(1, 4'h2, 0, 0, 1, FETCH_RST));
    st.push_back(stp(0, 4'h2, 0, 0, 1, FETCH_RDY));
    st.push_back(stp(0, 4'h2, 0, 0, 1, ev(1,0,0,2'b01,0,0,1,1,0,0,0)));
    for (int i = 0; i < st.size(); i++) begin
      Reset = st[i].rst; F = st[i].f; N = st[i].n; Z = st[i].z; Mem_Ready = st[i].mr;
      sb.push_back(st[i].exp);
      #3;
      want = sb.pop_front(); got = obs(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL halt step %0d: got %b want %b", i, got, want);
      end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    Reset     = 1'b1;
    F         = 4'h0;
    N         = 1'b0;
    Z         = 1'b0;
    Mem_Ready = 1'b0;
    @(posedge Clk); #1;
    test_reset();
    test_add_wait();
    test_jumps();
    test_sta();
    test_back_to_back();
    test_nop_and_reset_wait();
    test_halt();
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
